// File: rtl/ras_driver.sv
// ras_driver: decodes RV32 calls/returns into RAS push/pop ops, tracks in-flight ops
// per speculative stage, forwards commit/flush and registers the popped return target.
module ras_driver #(
   parameter int STAGES           = 2,
   parameter int WIDTH            = 31,
   parameter int SCRATCHPAD_DEPTH = 16
) (
   input  logic              clk,
   input  logic              rst_ni,
   input  logic              if_valid_i,
   output logic              if_ready_o,
   input  logic [WIDTH:0]    if_pc_i,
   input  logic [31:0]       if_instr_i,
   input  logic [STAGES-1:0] commit_i,
   input  logic [STAGES-1:0] flush_i,
   output logic              ras_push_o,
   output logic              ras_pop_o,
   output logic [WIDTH-1:0]  ras_din_o,
   output logic [STAGES-1:0] ras_commit_o,
   output logic [STAGES-1:0] ras_flush_o,
   output logic              ras_rst_o,
   input  logic [WIDTH-1:0]  ras_dout_i,
   input  logic              ras_valid_i,
   output logic              pred_valid_o,
   output logic [WIDTH:0]    pred_target_o
);
   localparam int CW = $clog2(SCRATCHPAD_DEPTH) + 1;
   localparam int PW = WIDTH + 1;
   typedef enum logic [1:0] {RESET, RUN, RECOVER} state_t;
   state_t            r_state, w_next;
   logic [CW-1:0]     r_cnt [STAGES];
   logic              r_pred_valid;
   logic [WIDTH:0]    r_pred_target;
   logic [4:0]        w_rd, w_rs1;
   logic              w_rd_link, w_rs1_link, w_jal, w_jalr, w_push, w_pop, w_fire, w_run, w_any_flush;
   logic [WIDTH:0]    w_pc4;
   logic [STAGES-1:0] w_mask, w_commit, w_inc;
   assign w_rd        = if_instr_i[11:7];
   assign w_rs1       = if_instr_i[19:15];
   assign w_rd_link   = (w_rd == 5'd1) || (w_rd == 5'd5);
   assign w_rs1_link  = (w_rs1 == 5'd1) || (w_rs1 == 5'd5);
   assign w_jal       = if_instr_i[6:0] == 7'b1101111;
   assign w_jalr      = (if_instr_i[6:0] == 7'b1100111) && (if_instr_i[14:12] == 3'b000);
   // every JAL/JALR that writes a link register pushes; a differing link rs1 additionally pops
   assign w_push      = (w_jal || w_jalr) && w_rd_link;
   assign w_pop       = w_jalr && w_rs1_link && (!w_rd_link || (w_rd != w_rs1));
   assign w_run       = r_state == RUN;
   assign w_any_flush = |flush_i;
   assign if_ready_o  = w_run && !((r_cnt[0] == CW'(SCRATCHPAD_DEPTH)) && !commit_i[0]);
   assign w_fire      = if_valid_i && if_ready_o;
   assign ras_push_o  = w_fire && w_push;
   assign ras_pop_o   = w_fire && w_pop;
   assign w_pc4       = if_pc_i + PW'(4);
   assign ras_din_o   = w_pc4[WIDTH:1];
   assign ras_rst_o   = r_state == RESET;
   assign ras_flush_o = ras_rst_o ? '0 : w_mask;
   assign ras_commit_o = w_commit;
   assign w_inc       = (w_commit << 1) | STAGES'(ras_push_o || ras_pop_o);
   assign pred_valid_o  = r_pred_valid;
   assign pred_target_o = r_pred_target;
   // a flush of stage k wipes every younger stage as well
   always_comb begin
      w_mask   = '0;
      w_commit = '0;
      for (int j = 0; j < STAGES; j++) begin
         w_mask[j]   = |(flush_i >> j);
         w_commit[j] = w_run && commit_i[j] && (r_cnt[j] != '0) && !w_mask[j];
      end
   end
   always_comb begin
      w_next = RUN;
      if (!ras_rst_o && w_any_flush) w_next = RECOVER;
   end
   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state       <= RESET;
         r_pred_valid  <= 1'b0;
         r_pred_target <= '0;
         for (int i = 0; i < STAGES; i++) r_cnt[i] <= '0;
      end else begin
         r_state      <= w_next;
         r_pred_valid <= ras_pop_o && ras_valid_i && !w_any_flush;
         if (ras_pop_o) r_pred_target <= {ras_dout_i, 1'b0};
         for (int i = 0; i < STAGES; i++)
            r_cnt[i] <= w_mask[i] ? '0 : r_cnt[i] + CW'(w_inc[i]) - CW'(w_commit[i]);
      end
   end
endmodule
